// File: rtl/plic_pkg.sv
// plic_pkg: shared types and constants for the PLIC source stage.
//   gw_state_t    : per-source gateway state
//   *_BASE_DEF    : default register window base addresses
//   id_w()        : width of a source ID for a given source count (min 1)
package plic_pkg;

  typedef enum logic [1:0] {
    GW_IDLE       = 2'd0,
    GW_PENDING    = 2'd1,
    GW_IN_SERVICE = 2'd2
  } gw_state_t;

  localparam logic [31:0] PRIO_BASE_DEF = 32'h0000_0000;
  localparam logic [31:0] PEND_BASE_DEF = 32'h0000_1000;
  localparam logic [31:0] MODE_BASE_DEF = 32'h0000_1080;

  function automatic int unsigned id_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/plic_gateway.sv
// plic_gateway: one interrupt source gateway.
//   clk, n_rst     : clock, asynchronous active-low reset
//   i_irq          : masked source level
//   i_edge_mode    : 1 = edge trigger, 0 = level trigger
//   i_claim        : claim addressed to this source
//   i_complete     : completion addressed to this source
//   i_sw_set       : software pending write with bit = 1
//   i_sw_clr       : software pending write with bit = 0
//   i_cnt_clr      : mode write setting this source to level
//   o_pending      : source is PENDING
//   o_in_service   : source is IN_SERVICE
module plic_gateway
  import plic_pkg::*;
#(
  parameter int unsigned EDGE_CNT_W = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_irq,
  input  logic i_edge_mode,
  input  logic i_claim,
  input  logic i_complete,
  input  logic i_sw_set,
  input  logic i_sw_clr,
  input  logic i_cnt_clr,
  output logic o_pending,
  output logic o_in_service
);

  localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;

  gw_state_t             r_state;
  logic                  r_prev;
  logic [EDGE_CNT_W-1:0] r_cnt;
  logic                  r_pending;
  logic                  r_in_service;

  logic                  w_edge;
  logic                  w_trig;
  logic                  w_done;
  logic [EDGE_CNT_W-1:0] w_cnt_inc;

  assign w_edge = i_irq & ~r_prev;
  assign w_trig = i_edge_mode ? w_edge : i_irq;
  // a claim for this source in the same cycle suppresses its completion
  assign w_done = i_complete & ~i_claim;
  // edge arriving this cycle is counted before any completion decision
  assign w_cnt_inc = (i_edge_mode && w_edge && (r_cnt != CNT_MAX)) ?
                     r_cnt + EDGE_CNT_W'(1) : r_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= GW_IDLE;
      r_prev       <= 1'b0;
      r_cnt        <= '0;
      r_pending    <= 1'b0;
      r_in_service <= 1'b0;
    end else begin
      r_prev <= i_irq;
      case (r_state)
        GW_IDLE: begin
          if (w_trig || i_sw_set) begin
            r_state   <= GW_PENDING;
            r_pending <= 1'b1;
          end
        end
        GW_PENDING: begin
          r_cnt <= i_cnt_clr ? '0 : w_cnt_inc;
          if (i_claim) begin
            r_state      <= GW_IN_SERVICE;
            r_pending    <= 1'b0;
            r_in_service <= 1'b1;
          end else if (i_sw_clr) begin
            r_state   <= GW_IDLE;
            r_pending <= 1'b0;
            r_cnt     <= '0;
          end
        end
        GW_IN_SERVICE: begin
          r_cnt <= i_cnt_clr ? '0 : w_cnt_inc;
          if (w_done) begin
            r_in_service <= 1'b0;
            if (i_edge_mode && (w_cnt_inc != '0)) begin
              r_state   <= GW_PENDING;
              r_pending <= 1'b1;
              r_cnt     <= i_cnt_clr ? '0 : w_cnt_inc - EDGE_CNT_W'(1);
            end else begin
              r_state <= GW_IDLE;
            end
          end
        end
        default: begin
          r_state      <= GW_IDLE;
          r_pending    <= 1'b0;
          r_in_service <= 1'b0;
          r_cnt        <= '0;
        end
      endcase
    end
  end

  assign o_pending    = r_pending;
  assign o_in_service = r_in_service;

endmodule

// File: rtl/plic_gateway_pending_priority.sv
// plic_gateway_pending_priority: PLIC source stage (gateways, pending, priority, mode).
//   clk, n_rst              : clock, asynchronous active-low reset
//   irq_src                 : masked interrupt sources
//   claim / claim_id        : claim pulse and claimed source
//   complete / complete_id  : completion pulse and completed source
//   pending / in_service    : per-source gateway state
//   priority_flat           : priority of source i at [i*PRIO_W +: PRIO_W]
//   addr/wen/wdata/rdata    : register port, combinational read
//   addr_valid              : addr falls in the priority, pending or mode window
module plic_gateway_pending_priority
  import plic_pkg::*;
#(
  parameter int unsigned N_SOURCES  = 32,
  parameter int unsigned PRIO_W     = 3,
  parameter int unsigned EDGE_CNT_W = 2,
  parameter logic [31:0] PRIO_BASE  = PRIO_BASE_DEF,
  parameter logic [31:0] PEND_BASE  = PEND_BASE_DEF,
  parameter logic [31:0] MODE_BASE  = MODE_BASE_DEF,
  localparam int unsigned ID_W      = id_w(N_SOURCES)
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [N_SOURCES-1:0]          irq_src,
  input  logic                          claim,
  input  logic [ID_W-1:0]               claim_id,
  input  logic                          complete,
  input  logic [ID_W-1:0]               complete_id,
  output logic [N_SOURCES-1:0]          pending,
  output logic [N_SOURCES-1:0]          in_service,
  output logic [N_SOURCES*PRIO_W-1:0]   priority_flat,
  input  logic [31:0]                   addr,
  input  logic                          wen,
  input  logic [31:0]                   wdata,
  output logic [31:0]                   rdata,
  output logic                          addr_valid
);

  localparam int unsigned N_WORDS = (N_SOURCES + 31) / 32;
  localparam int unsigned PAD_W   = N_WORDS * 32;

  logic [31:0]          w_off_prio, w_off_pend, w_off_mode;
  logic [31:0]          w_prio_idx, w_pend_word, w_mode_word;
  logic                 w_hit_prio, w_hit_pend, w_hit_mode;
  logic [N_SOURCES-1:0] w_mode;
  logic [PAD_W-1:0]     w_pend_pad, w_mode_pad;
  logic [PRIO_W-1:0]    w_prio_rd;

  // offsets wrap below the base, so one unsigned compare bounds each window
  assign w_off_prio  = addr - PRIO_BASE;
  assign w_off_pend  = addr - PEND_BASE;
  assign w_off_mode  = addr - MODE_BASE;
  assign w_hit_prio  = w_off_prio < (PEND_BASE - PRIO_BASE);
  assign w_hit_pend  = w_off_pend < (MODE_BASE - PEND_BASE);
  assign w_hit_mode  = w_off_mode < 32'(4 * N_WORDS);
  assign w_prio_idx  = w_off_prio >> 2;
  assign w_pend_word = w_off_pend >> 2;
  assign w_mode_word = w_off_mode >> 2;

  for (genvar gi = 0; gi < N_SOURCES; gi++) begin : g_src
    localparam int unsigned WRD = gi / 32;
    localparam int unsigned BIT = gi % 32;

    logic              r_mode;
    logic [PRIO_W-1:0] r_prio;
    logic              w_claim_hit, w_complete_hit, w_pend_wr, w_cnt_clr;

    assign w_claim_hit    = claim && (claim_id == ID_W'(gi));
    assign w_complete_hit = complete && (complete_id == ID_W'(gi));
    assign w_pend_wr      = wen && w_hit_pend && (w_pend_word == WRD);
    assign w_cnt_clr      = wen && w_hit_mode && (w_mode_word == WRD) && !wdata[BIT];

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        r_mode <= 1'b0;
        r_prio <= '0;
      end else begin
        if (wen && w_hit_mode && (w_mode_word == WRD)) r_mode <= wdata[BIT];
        if (wen && w_hit_prio && (w_prio_idx == gi))   r_prio <= wdata[PRIO_W-1:0];
      end
    end

    assign w_mode[gi] = r_mode;
    assign priority_flat[gi*PRIO_W +: PRIO_W] = r_prio;

    plic_gateway #(.EDGE_CNT_W(EDGE_CNT_W)) u_gw (
      .clk          (clk),
      .n_rst        (n_rst),
      .i_irq        (irq_src[gi]),
      .i_edge_mode  (r_mode),
      .i_claim      (w_claim_hit),
      .i_complete   (w_complete_hit),
      .i_sw_set     (w_pend_wr && wdata[BIT]),
      .i_sw_clr     (w_pend_wr && !wdata[BIT]),
      .i_cnt_clr    (w_cnt_clr),
      .o_pending    (pending[gi]),
      .o_in_service (in_service[gi])
    );
  end

  assign w_pend_pad = PAD_W'(pending);
  assign w_mode_pad = PAD_W'(w_mode);
  assign w_prio_rd  = PRIO_W'(priority_flat >> (w_prio_idx * PRIO_W));

  always_comb begin
    rdata      = '0;
    addr_valid = w_hit_prio || w_hit_pend || w_hit_mode;
    if (w_hit_prio) begin
      if (w_prio_idx < N_SOURCES) rdata = 32'(w_prio_rd);
    end else if (w_hit_pend) begin
      if (w_pend_word < N_WORDS) rdata = 32'(w_pend_pad >> (w_pend_word << 5));
    end else if (w_hit_mode) begin
      rdata = 32'(w_mode_pad >> (w_mode_word << 5));
    end
  end

endmodule

// File: tb/tb_plic_gateway_pending_priority.sv
module tb_plic_gateway_pending_priority;

  localparam int N    = 40;
  localparam int PW   = 3;
  localparam int CMAX = 3;
  localparam logic [31:0] PRIO_B = 32'h0000_0000;
  localparam logic [31:0] PEND_B = 32'h0000_1000;
  localparam logic [31:0] MODE_B = 32'h0000_1080;

  logic          clk, n_rst;
  logic [N-1:0]  irq_src;
  logic          claim, complete, wen;
  logic [5:0]    claim_id, complete_id;
  logic [N-1:0]  pending, in_service;
  logic [N*PW-1:0] priority_flat;
  logic [31:0]   addr, wdata, rdata;
  logic          addr_valid;

  int checks, errors;

  // model: 0 idle, 1 pending, 2 in service
  int st[N];
  int cnt[N];
  int mode[N];
  int prio[N];
  bit prev[N];

  plic_gateway_pending_priority #(
    .N_SOURCES(N), .PRIO_W(PW), .EDGE_CNT_W(2),
    .PRIO_BASE(PRIO_B), .PEND_BASE(PEND_B), .MODE_BASE(MODE_B)
  ) dut (
    .clk(clk), .n_rst(n_rst), .irq_src(irq_src),
    .claim(claim), .claim_id(claim_id),
    .complete(complete), .complete_id(complete_id),
    .pending(pending), .in_service(in_service), .priority_flat(priority_flat),
    .addr(addr), .wen(wen), .wdata(wdata), .rdata(rdata), .addr_valid(addr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      st[i] = 0; cnt[i] = 0; mode[i] = 0; prio[i] = 0; prev[i] = 1'b0;
    end
  endtask

  task automatic model_read(input logic [31:0] a, output logic v, output logic [31:0] d);
    int w;
    v = 1'b0; d = '0;
    if (a < 32'h1000) begin
      v = 1'b1;
      if ((a >> 2) < N) d = 32'(prio[a >> 2]);
    end else if (a < 32'h1080) begin
      v = 1'b1;
      w = int'((a - 32'h1000) >> 2);
      for (int b = 0; b < 32; b++)
        if (w * 32 + b < N && st[w * 32 + b] == 1) d[b] = 1'b1;
    end else if (a < 32'h1088) begin
      v = 1'b1;
      w = int'((a - 32'h1080) >> 2);
      for (int b = 0; b < 32; b++)
        if (w * 32 + b < N && mode[w * 32 + b] != 0) d[b] = 1'b1;
    end
  endtask

  task automatic model_step();
    bit e, trig, cl, cp, pw, mw;
    int wsel;
    for (int i = 0; i < N; i++) begin
      e    = irq_src[i] && !prev[i];
      trig = (mode[i] != 0) ? e : irq_src[i];
      cl   = claim && (int'(claim_id) == i);
      cp   = complete && (int'(complete_id) == i) && !cl;
      pw   = wen && addr >= 32'h1000 && addr < 32'h1080 && int'((addr - 32'h1000) >> 2) == i / 32;
      mw   = wen && addr >= 32'h1080 && addr < 32'h1088 && int'((addr - 32'h1080) >> 2) == i / 32;
      if (st[i] != 0 && mode[i] != 0 && e && cnt[i] < CMAX) cnt[i]++;
      if (st[i] == 0) begin
        if (trig || (pw && wdata[i % 32])) st[i] = 1;
      end else if (st[i] == 1) begin
        if (cl) st[i] = 2;
        else if (pw && !wdata[i % 32]) begin st[i] = 0; cnt[i] = 0; end
      end else if (cp) begin
        if (mode[i] != 0 && cnt[i] > 0) begin st[i] = 1; cnt[i]--; end
        else st[i] = 0;
      end
      if (mw) begin
        if (!wdata[i % 32]) cnt[i] = 0;
        mode[i] = wdata[i % 32] ? 1 : 0;
      end
      prev[i] = irq_src[i];
    end
    if (wen && addr < 32'h1000) begin
      wsel = int'(addr >> 2);
      if (wsel < N) prio[wsel] = int'(wdata[PW-1:0]);
    end
  endtask

  // one clock: check combinational read, advance model, compare registered outputs
  task automatic tick();
    logic ev;
    logic [31:0] er;
    logic [N-1:0] ep, ei;
    logic [N*PW-1:0] ef;
    #1;
    model_read(addr, ev, er);
    chk("rdata", rdata, er);
    chk("addr_valid", addr_valid, ev);
    model_step();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      ep[i] = (st[i] == 1);
      ei[i] = (st[i] == 2);
      ef[i*PW +: PW] = PW'(prio[i]);
    end
    chk("pending", pending, ep);
    chk("in_service", in_service, ei);
    chk("priority_flat", priority_flat, ef);
    claim = 1'b0; complete = 1'b0; wen = 1'b0;
  endtask

  task automatic set_wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
  endtask

  task automatic do_claim(input int id);
    claim = 1'b1; claim_id = 6'(id);
  endtask

  task automatic do_complete(input int id);
    complete = 1'b1; complete_id = 6'(id);
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    irq_src = '0; claim = 0; complete = 0; wen = 0; addr = '0; wdata = '0;
    @(negedge clk);
    model_reset();
    n_rst = 1'b1;
  endtask

  function automatic int pick(input int want);
    int s;
    s = $urandom_range(0, N - 1);
    if ($urandom_range(0, 4) == 0) return $urandom_range(0, 63);
    for (int k = 0; k < N; k++)
      if (st[(s + k) % N] == want) return (s + k) % N;
    return $urandom_range(0, 63);
  endfunction

  initial begin
    checks = 0; errors = 0;
    n_rst = 1'b0;
    irq_src = '0; claim = 0; complete = 0; wen = 0;
    claim_id = '0; complete_id = '0; addr = '0; wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pending", pending, '0);
    chk("rst_in_service", in_service, '0);
    chk("rst_prio", priority_flat, '0);
    n_rst = 1'b1;

    // level source 5, single-cycle pulse
    irq_src[5] = 1'b1; tick(); irq_src[5] = 1'b0;
    chk("lvl5_pend", pending[5], 1'b1);
    do_claim(5); tick();
    chk("lvl5_claim_is", in_service[5], 1'b1);
    chk("lvl5_claim_pd", pending[5], 1'b0);
    do_complete(5); tick();
    chk("lvl5_done", in_service[5], 1'b0);

    // level source 5 held high across completion
    irq_src[5] = 1'b1; tick();
    do_claim(5); tick();
    do_complete(5); tick();
    chk("lvl5_idle_gap", pending[5], 1'b0);
    tick();
    chk("lvl5_repend", pending[5], 1'b1);
    irq_src[5] = 1'b0; do_claim(5); tick();
    do_complete(5); tick();

    // edge source 3 with saturating counter
    set_wr(MODE_B, 32'h8); tick();
    irq_src[3] = 1'b1; tick();
    chk("edge3_pend", pending[3], 1'b1);
    irq_src[3] = 1'b0; do_claim(3); tick();
    chk("edge3_is", in_service[3], 1'b1);
    repeat (4) begin
      irq_src[3] = 1'b1; tick();
      irq_src[3] = 1'b0; tick();
    end
    for (int k = 0; k < 4; k++) begin
      do_complete(3); tick();
      chk("edge3_repend", pending[3], (k < 3) ? 1'b1 : 1'b0);
      if (k < 3) begin do_claim(3); tick(); end
    end
    irq_src[3] = 1'b1; tick();
    irq_src[3] = 1'b0; do_claim(3); tick();
    irq_src[3] = 1'b1; do_complete(3); tick();
    chk("edge3_on_complete", pending[3], 1'b1);
    irq_src[3] = 1'b0; do_claim(3); tick();
    do_complete(3); tick();
    chk("edge3_final_idle", {pending[3], in_service[3]}, 2'b00);
    set_wr(MODE_B, 32'h0); tick();

    // priority and register windows
    set_wr(PRIO_B + 32'd28, 32'hFFFF_FFFD); tick();
    addr = PRIO_B + 32'd28; #1;
    chk("prio7_read", rdata, 32'h5);
    chk("prio7_flat", priority_flat[7*PW +: PW], 3'd5);
    irq_src[33] = 1'b1; tick(); irq_src[33] = 1'b0;
    addr = PEND_B + 32'd4; #1;
    chk("pend_word1", rdata, 32'h2);
    do_claim(33); tick();
    do_complete(33); tick();
    set_wr(PRIO_B + 32'd180, 32'h7); tick();
    addr = PRIO_B + 32'd180; #1;
    chk("prio45_read", rdata, 32'h0);
    chk("prio45_valid", addr_valid, 1'b1);
    addr = 32'h0000_2000; #1;
    chk("oor_valid", addr_valid, 1'b0);

    // software pending writes and ignored claims
    set_wr(PEND_B, 32'h1); tick();
    chk("sw_set0", pending[0], 1'b1);
    set_wr(PEND_B, 32'h0); do_claim(0); tick();
    chk("claim_beats_clr", in_service[0], 1'b1);
    do_complete(0); tick();
    do_claim(9); tick();
    chk("claim_idle9", {pending, in_service}, '0);

    // randomized phase
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 1) == 0) irq_src[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 2) == 0) do_claim(pick(1));
      if ($urandom_range(0, 2) == 0) do_complete(pick(2));
      case ($urandom_range(0, 4))
        0: addr = PRIO_B + 32'($urandom_range(0, 50) * 4 + $urandom_range(0, 3));
        1: addr = PEND_B + 32'($urandom_range(0, 2) * 4 + $urandom_range(0, 3));
        2: addr = MODE_B + 32'($urandom_range(0, 2) * 4 + $urandom_range(0, 3));
        3: addr = $urandom;
        default: addr = PEND_B;
      endcase
      wdata = $urandom;
      wen = ($urandom_range(0, 9) == 0);
      tick();
    end

    // asynchronous reset while source 3 is in service with queued edges
    do_reset();
    set_wr(MODE_B, 32'h8); tick();
    irq_src[3] = 1'b1; tick();
    irq_src[3] = 1'b0; do_claim(3); tick();
    repeat (2) begin
      irq_src[3] = 1'b1; tick();
      irq_src[3] = 1'b0; tick();
    end
    chk("pre_rst_is3", in_service[3], 1'b1);
    #2 n_rst = 1'b0;
    #1;
    chk("async_rst_pend", pending, '0);
    chk("async_rst_is", in_service, '0);
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", {pending, in_service}, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
